imem_boot_arbiter: RTL and testbench

- Controls the single-port instruction memory and shares it between two requesters: the core's fetch port and a word-wide boot loader.
- After reset it runs a LOAD phase, writing loader words to sequential word addresses from 0. It then releases the core with cpu_run.
- In RUN it serves fetch reads and arbitrates them against loader patch writes, using a starvation guard so patches are never blocked forever.

---
 rtl/imem_boot_arbiter.sv | 148 ++++++++++++++
 tb/tb_imem_boot_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_arbiter.sv
// ============================================================================
// Module      : imem_boot_arbiter
// Description : Instruction-memory controller. Boot-loads words from address 0,
//               then arbitrates core fetches against loader patch writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_arbiter #(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ld_valid,
    output logic          o_ld_ready,
    input  logic [31:0]   i_ld_data,
    input  logic [AW-1:0] i_ld_addr,
    input  logic          i_ld_last,
    input  logic          i_fetch_req,
    input  logic [31:0]   i_fetch_addr,
    output logic          o_fetch_gnt,
    output logic          o_fetch_rvalid,
    output logic [31:0]   o_fetch_rdata,
    output logic          o_fetch_err,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_cpu_run,
    output logic [AW:0]   o_load_count
);

    localparam int            SW             = $clog2(STARVE + 1);
    localparam logic [SW-1:0] c_STARVE_MAX   = SW'(STARVE);
    localparam logic [AW:0]   c_LAST_IDX     = (AW + 1)'(DEPTH - 1);
    localparam logic [31:0]   c_ADDR_LIMIT   = 32'(DEPTH * 4);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_load_count;
    logic [SW-1:0] r_starve;
    logic          r_cpu_run;
    logic          r_rvalid;
    logic          r_err;
    logic          r_rd_ok;

    logic          w_ld_gnt;
    logic          w_ld_rdy;
    logic          w_f_gnt;
    logic          w_bad;
    logic [AW-1:0] w_word;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;

    assign w_bad  = (i_fetch_addr[1:0] != 2'b00) || (i_fetch_addr >= c_ADDR_LIMIT);
    assign w_word = i_fetch_addr[AW+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_ld_gnt    = 1'b0;
        w_ld_rdy    = 1'b0;
        w_f_gnt     = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        case (r_state)
            S_LOAD: begin
                w_ld_rdy = 1'b1;
                w_ld_gnt = i_ld_valid;
                if (i_ld_valid) begin
                    w_mem_en   = 1'b1;
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_load_count[AW-1:0];
                    if (i_ld_last || (r_load_count == c_LAST_IDX)) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                // Fetch wins unless the loader has waited out its starvation budget.
                w_ld_gnt = i_ld_valid && (!i_fetch_req || (r_starve == c_STARVE_MAX));
                w_f_gnt  = i_fetch_req && !w_ld_gnt;
                w_ld_rdy = w_ld_gnt;
                if (w_ld_gnt) begin
                    w_mem_en   = 1'b1;
                    w_mem_we   = 1'b1;
                    w_mem_addr = i_ld_addr;
                end else if (w_f_gnt && !w_bad) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = w_word;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_load_count <= '0;
            r_starve     <= '0;
            r_cpu_run    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rd_ok      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_run <= (w_state_nxt == S_RUN);
            r_rvalid  <= w_f_gnt;
            r_err     <= w_f_gnt && w_bad;
            r_rd_ok   <= w_f_gnt && !w_bad;
            if ((r_state == S_LOAD) && w_ld_gnt) begin
                r_load_count <= r_load_count + 1'b1;
            end
            if (i_ld_valid && !w_ld_gnt) begin
                if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                r_starve <= '0;
            end
        end
    end

    // Memory read data arrives the cycle after the grant, aligned with r_rd_ok.
    assign o_fetch_rdata  = r_rd_ok ? i_mem_rdata : 32'h0;
    assign o_fetch_rvalid = r_rvalid;
    assign o_fetch_err    = r_err;
    assign o_cpu_run      = r_cpu_run;
    assign o_load_count   = r_load_count;
    assign o_ld_ready     = rst_n && w_ld_rdy;
    assign o_fetch_gnt    = rst_n && w_f_gnt;
    assign o_mem_en       = rst_n && w_mem_en;
    assign o_mem_we       = rst_n && w_mem_we;
    assign o_mem_addr     = w_mem_addr;
    assign o_mem_wdata    = i_ld_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_arbiter.sv
// ============================================================================
// Module      : tb_imem_boot_arbiter
// Description : Self-checking bench for imem_boot_arbiter with an attached RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_arbiter;

    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_valid, ld_ready, ld_last;
    logic [31:0]   ld_data;
    logic [AW-1:0] ld_addr;
    logic          fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0]   fetch_addr, fetch_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic          cpu_run;
    logic [AW:0]   load_count;

    logic [31:0]   ram    [DEPTH];
    logic [31:0]   shadow [DEPTH];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    imem_boot_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE(STARVE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ld_valid     (ld_valid),
        .o_ld_ready     (ld_ready),
        .i_ld_data      (ld_data),
        .i_ld_addr      (ld_addr),
        .i_ld_last      (ld_last),
        .i_fetch_req    (fetch_req),
        .i_fetch_addr   (fetch_addr),
        .o_fetch_gnt    (fetch_gnt),
        .o_fetch_rvalid (fetch_rvalid),
        .o_fetch_rdata  (fetch_rdata),
        .o_fetch_err    (fetch_err),
        .o_mem_en       (mem_en),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .o_cpu_run      (cpu_run),
        .o_load_count   (load_count)
    );

    task automatic test_reset();
        rst_n = 1'b0; ld_valid = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
        ld_data = 32'h0; ld_addr = '0; ld_last = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset ld_ready got=%b exp=0", ld_ready); end
        checks++; if (fetch_gnt !== 1'b0) begin failures++; $display("FAIL reset fetch_gnt got=%b exp=0", fetch_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset mem_en/we got=%b%b exp=00", mem_en, mem_we); end
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL reset cpu_run got=%b exp=0", cpu_run); end
        checks++; if (load_count !== '0) begin failures++; $display("FAIL reset load_count got=%0d exp=0", load_count); end
        checks++; if (fetch_rvalid !== 1'b0 || fetch_err !== 1'b0 || fetch_rdata !== 32'h0) begin
            failures++; $display("FAIL reset fetch_resp got=%b/%b/%h exp=0/0/0", fetch_rvalid, fetch_err, fetch_rdata);
        end
        ld_valid = 1'b0; fetch_req = 1'b0;
    endtask

    task automatic test_boot(input int n, input bit use_last);
        logic [31:0] words [3];
        logic [31:0] w;
        words[0] = 32'h0000_0013; words[1] = 32'h0198_06B3; words[2] = 32'h4034_02B3;
        @(negedge clk); rst_n = 1'b0; ld_valid = 1'b0; fetch_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w = (n == 3) ? words[i] : $urandom;
            ld_valid = 1'b1; ld_data = w; ld_last = use_last && (i == n - 1);
            fetch_req = 1'b1; fetch_addr = 32'h4;
            #1;
            checks++; if (ld_ready !== 1'b1 || fetch_gnt !== 1'b0) begin
                failures++; $display("FAIL boot beat%0d ready/gnt got=%b%b exp=10", i, ld_ready, fetch_gnt);
            end
            checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== w) begin
                failures++; $display("FAIL boot beat%0d write got=%b%b a=%0d d=%h exp=11 a=%0d d=%h", i, mem_en, mem_we, mem_addr, mem_wdata, i, w);
            end
            checks++; if (load_count !== (AW+1)'(i) || cpu_run !== 1'b0) begin
                failures++; $display("FAIL boot beat%0d count/run got=%0d/%b exp=%0d/0", i, load_count, cpu_run, i);
            end
            shadow[i] = w;
        end
        @(negedge clk); ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0;
        #1;
        checks++; if (cpu_run !== 1'b1 || load_count !== (AW+1)'(n)) begin
            failures++; $display("FAIL boot done run/count got=%b/%0d exp=1/%0d", cpu_run, load_count, n);
        end
    endtask

    task automatic test_run_patch();
        logic [31:0] w;
        w = $urandom;
        @(negedge clk); ld_valid = 1'b1; ld_addr = AW'(7); ld_data = w; fetch_req = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(7) || mem_wdata !== w) begin
            failures++; $display("FAIL patch got rdy=%b we=%b a=%0d d=%h exp 1 1 7 %h", ld_ready, mem_we, mem_addr, mem_wdata, w);
        end
        shadow[7] = w;
        @(negedge clk); ld_valid = 1'b0;
        #1;
        checks++; if (load_count !== (AW+1)'(DEPTH)) begin failures++; $display("FAIL patch load_count got=%0d exp=%0d", load_count, DEPTH); end
    endtask

    task automatic test_fetch_b2b();
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h4;
        #1;
        checks++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(1)) begin
            failures++; $display("FAIL b2b first got gnt=%b en=%b we=%b a=%0d exp 1 1 0 1", fetch_gnt, mem_en, mem_we, mem_addr);
        end
        @(negedge clk); fetch_addr = 32'h8;
        #1;
        checks++; if (fetch_gnt !== 1'b1 || mem_addr !== AW'(2)) begin
            failures++; $display("FAIL b2b second got gnt=%b a=%0d exp 1 2", fetch_gnt, mem_addr);
        end
        checks++; if (fetch_rvalid !== 1'b1 || fetch_err !== 1'b0 || fetch_rdata !== shadow[1]) begin
            failures++; $display("FAIL b2b resp1 got %b %b %h exp 1 0 %h", fetch_rvalid, fetch_err, fetch_rdata, shadow[1]);
        end
        @(negedge clk); fetch_req = 1'b0;
        #1;
        checks++; if (fetch_rvalid !== 1'b1 || fetch_err !== 1'b0 || fetch_rdata !== shadow[2]) begin
            failures++; $display("FAIL b2b resp2 got %b %b %h exp 1 0 %h", fetch_rvalid, fetch_err, fetch_rdata, shadow[2]);
        end
        @(negedge clk); #1;
        checks++; if (fetch_rvalid !== 1'b0) begin failures++; $display("FAIL b2b idle rvalid got=%b exp=0", fetch_rvalid); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] bad [2];
        bad[0] = 32'h6; bad[1] = 32'h100;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); fetch_req = 1'b1; fetch_addr = bad[k];
            #1;
            checks++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin
                failures++; $display("FAIL bad %h gnt/en got=%b%b exp=10", bad[k], fetch_gnt, mem_en);
            end
            @(negedge clk); fetch_req = 1'b0;
            #1;
            checks++; if (fetch_rvalid !== 1'b1 || fetch_err !== 1'b1 || fetch_rdata !== 32'h0) begin
                failures++; $display("FAIL bad %h resp got %b %b %h exp 1 1 0", bad[k], fetch_rvalid, fetch_err, fetch_rdata);
            end
        end
    endtask

    task automatic test_starve();
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        ld_valid = 1'b1; ld_addr = AW'(5); ld_data = 32'hDEAD_BEEF;
        for (int k = 0; k <= STARVE; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k < STARVE) begin
                checks++; if (ld_ready !== 1'b0 || fetch_gnt !== 1'b1) begin
                    failures++; $display("FAIL starve cyc%0d rdy/gnt got=%b%b exp=01", k, ld_ready, fetch_gnt);
                end
            end else begin
                checks++; if (ld_ready !== 1'b1 || fetch_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AW'(5) || mem_wdata !== 32'hDEAD_BEEF) begin
                    failures++; $display("FAIL starve forced got rdy=%b gnt=%b we=%b a=%0d d=%h", ld_ready, fetch_gnt, mem_we, mem_addr, mem_wdata);
                end
            end
        end
        shadow[5] = 32'hDEAD_BEEF;
        @(negedge clk); ld_valid = 1'b0; fetch_addr = 32'h14;
        #1;
        checks++; if (fetch_gnt !== 1'b1 || fetch_rvalid !== 1'b0) begin
            failures++; $display("FAIL starve retry gnt/rvalid got=%b%b exp=10", fetch_gnt, fetch_rvalid);
        end
        @(negedge clk); fetch_req = 1'b0;
        #1;
        checks++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL starve readback got %b %h exp 1 deadbeef", fetch_rvalid, fetch_rdata);
        end
    endtask

    task automatic test_reset_in_run();
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h0; ld_valid = 1'b0;
        @(posedge clk); #2; fetch_req = 1'b0;
        #1;
        checks++; if (fetch_rvalid !== 1'b1) begin failures++; $display("FAIL rstrun inflight rvalid got=%b exp=1", fetch_rvalid); end
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_rvalid !== 1'b0 || cpu_run !== 1'b0) begin
            failures++; $display("FAIL rstrun abort rvalid/run got=%b%b exp=00", fetch_rvalid, cpu_run);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); ld_valid = 1'b1; ld_data = 32'hCAFE_0001; ld_last = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(0) || load_count !== '0) begin
            failures++; $display("FAIL rstrun reload got rdy=%b we=%b a=%0d cnt=%0d exp 1 1 0 0", ld_ready, mem_we, mem_addr, load_count);
        end
        shadow[0] = 32'hCAFE_0001;
        @(negedge clk); ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        checks++; if (cpu_run !== 1'b1 || load_count !== (AW+1)'(1)) begin
            failures++; $display("FAIL rstrun done run/count got=%b/%0d exp=1/1", cpu_run, load_count);
        end
    endtask

    // Reference: fetch has priority unless the loader has been refused STARVE times in a row.
    task automatic test_random(input int n);
        int          starve_m = 0;
        bit          prev_rv = 0, prev_err = 0;
        logic [31:0] prev_data = 32'h0;
        bit          ldg, fg, bad;
        int          word, sel;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            fetch_req = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            if (sel < 4)       fetch_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (sel == 4) fetch_addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else               fetch_addr = $urandom | 32'h100;
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_addr  = AW'($urandom_range(0, DEPTH - 1));
            ld_data  = $urandom;
            ld_last  = 1'($urandom_range(0, 1));
            bad  = (fetch_addr % 4 != 0) || (fetch_addr >= DEPTH * 4);
            word = int'(fetch_addr / 4) % DEPTH;
            ldg  = ld_valid && (!fetch_req || starve_m >= STARVE);
            fg   = fetch_req && !ldg;
            #1;
            checks++; if (ld_ready !== ldg || fetch_gnt !== fg) begin
                failures++; $display("FAIL rnd c%0d rdy/gnt got=%b%b exp=%b%b", c, ld_ready, fetch_gnt, ldg, fg);
            end
            checks++; if (mem_en !== (ldg || (fg && !bad)) || mem_we !== ldg) begin
                failures++; $display("FAIL rnd c%0d en/we got=%b%b exp=%b%b", c, mem_en, mem_we, ldg || (fg && !bad), ldg);
            end
            if (ldg) begin
                checks++; if (mem_addr !== ld_addr || mem_wdata !== ld_data) begin
                    failures++; $display("FAIL rnd c%0d wr got a=%0d d=%h exp a=%0d d=%h", c, mem_addr, mem_wdata, ld_addr, ld_data);
                end
            end else if (fg && !bad) begin
                checks++; if (mem_addr !== AW'(word)) begin
                    failures++; $display("FAIL rnd c%0d rd addr got=%0d exp=%0d", c, mem_addr, word);
                end
            end
            checks++; if (fetch_rvalid !== prev_rv || (prev_rv && (fetch_err !== prev_err || fetch_rdata !== prev_data))) begin
                failures++; $display("FAIL rnd c%0d resp got %b %b %h exp %b %b %h", c, fetch_rvalid, fetch_err, fetch_rdata, prev_rv, prev_err, prev_data);
            end
            prev_rv   = fg;
            prev_err  = fg && bad;
            prev_data = (fg && !bad) ? shadow[word] : 32'h0;
            if (ldg) shadow[ld_addr] = ld_data;
            starve_m  = (ld_valid && !ldg) ? ((starve_m < STARVE) ? starve_m + 1 : STARVE) : 0;
        end
        @(negedge clk); ld_valid = 1'b0; fetch_req = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot(3, 1'b1);
        test_fetch_b2b();
        test_bad_addr();
        test_starve();
        test_reset_in_run();
        test_boot(DEPTH, 1'b0);
        test_run_patch();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
